shift_cmd_fifo: RTL and testbench

SHIFT_CMD_FIFO -- requirements
Module: shift_cmd_fifo

---
 rtl/shift_cmd_fifo.sv | 93 +++++++++
 tb/tb_shift_cmd_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_fifo.sv
// Command queue feeding an external combinational barrel shifter, with a registered result stage.
// Result valid one edge after the push edge when idle; in_ready drops only when the queue is full.
module shift_cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_din,
   input  logic [2:0]               in_shamt,
   input  logic                     in_lr,
   input  logic                     in_al,
   output logic [7:0]               sh_din,
   output logic [2:0]               sh_shamt,
   output logic                     sh_lr,
   output logic                     sh_al,
   input  logic [7:0]               sh_dout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [7:0] din;
      logic [2:0] shamt;
      logic       lr;
      logic       al;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          in_cmd;
   cmd_t          head_cmd;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign in_cmd   = {in_din, in_shamt, in_lr, in_al};
   assign in_ready = (count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   // A pop only happens when the result register is free or being drained this cycle.
   assign pop      = (count != '0) && (!out_valid || out_ready);

   assign head_cmd = (count != '0) ? mem[rd_ptr] : '0;
   assign sh_din   = head_cmd.din;
   assign sh_shamt = head_cmd.shamt;
   assign sh_lr    = head_cmd.lr;
   assign sh_al    = head_cmd.al;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_cmd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else if (pop) begin
         out_valid <= 1'b1;
         out_data  <= sh_dout;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Randomized and directed bench for shift_cmd_fifo with a queue-level reference model and scoreboard.
module tb_shift_cmd_fifo;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_din = 8'h00;
   logic [2:0] in_shamt = 3'd0;
   logic       in_lr = 1'b0;
   logic       in_al = 1'b0;
   logic [7:0] sh_din;
   logic [2:0] sh_shamt;
   logic       sh_lr;
   logic       sh_al;
   logic [7:0] sh_dout;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   bit rnd_rdy = 0;
   bit mon_en = 0;

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       lr;
      logic       al;
   } cmd_t;

   cmd_t       m_q[$];
   logic [7:0] exp_q[$];
   bit         m_ov = 0;
   logic [7:0] m_od = 8'h00;
   bit         m_last_push = 0;
   int         m_push_total = 0;

   shift_cmd_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_din(in_din), .in_shamt(in_shamt), .in_lr(in_lr), .in_al(in_al),
      .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr), .sh_al(sh_al),
      .sh_dout(sh_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   always #5 clk = ~clk;

   // Stand-in for the external barrel shifter.
   always_comb begin
      sh_dout = 8'h00;
      if (sh_lr)
         sh_dout = sh_din << sh_shamt;
      else if (sh_al)
         sh_dout = 8'($signed(sh_din) >>> sh_shamt);
      else
         sh_dout = sh_din >> sh_shamt;
   end

   // Shift result by multiplication / floor division on integers.
   function automatic logic [7:0] ref_shift(input cmd_t c);
      int p, v, q;
      p = 1 << c.s;
      if (c.lr) return 8'((int'(c.d) * p) % 256);
      v = int'(c.d);
      if (c.al && c.d[7]) v = v - 256;
      q = v / p;
      if (v < 0 && q * p != v) q = q - 1;
      return 8'(q);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference model: queue of commands plus one result register.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         exp_q.delete();
         m_ov = 0;
         m_od = 8'h00;
         m_last_push = 0;
      end else begin
         bit   pop_now, push_now;
         cmd_t c;
         pop_now  = (m_q.size() > 0) && (!m_ov || out_ready);
         push_now = in_valid && (m_q.size() < DEPTH);
         if (pop_now) begin
            c = m_q.pop_front();
            m_ov = 1;
            m_od = ref_shift(c);
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (push_now) begin
            c.d = in_din; c.s = in_shamt; c.lr = in_lr; c.al = in_al;
            m_q.push_back(c);
            exp_q.push_back(ref_shift(c));
            m_push_total++;
         end
         m_last_push = push_now;
      end
   end

   // Monitor: compares DUT against the model each cycle and scores every handshake.
   initial forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
         chk("count", 32'(count), 32'(m_q.size()));
         chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
         if (m_q.size() > 0)
            chk("sh_cmd", 32'({sh_din, sh_shamt, sh_lr, sh_al}),
                32'({m_q[0].d, m_q[0].s, m_q[0].lr, m_q[0].al}));
         else
            chk("sh_zero", 32'({sh_din, sh_shamt, sh_lr, sh_al}), 32'(0));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra actual=%0h required=no_result", out_data);
            end else begin
               chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic junk();
      in_din   = 8'($urandom);
      in_shamt = 3'($urandom);
      in_lr    = 1'($urandom);
      in_al    = 1'($urandom);
   endtask

   task automatic push_cmd(input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al);
      bit ok;
      ok = 0;
      in_valid = 1'b1; in_din = d; in_shamt = s; in_lr = lr; in_al = al;
      for (int i = 0; i < 64 && !ok; i++) begin
         step();
         ok = m_last_push;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL push_timeout actual=not_accepted required=accepted");
      end
      in_valid = 1'b0;
      junk();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && !(m_q.size() == 0 && !m_ov); i++) step();
      chk("idle_reached", 32'(m_q.size() == 0 && !m_ov), 32'(1));
   endtask

   initial begin
      int start;
      junk();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_data", 32'(out_data), 32'(8'h00));
      chk("rst_sh_din", 32'(sh_din), 32'(8'h00));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      mon_en = 1;
      out_ready = 1'b1;

      // Single arithmetic right shift
      push_cmd(8'hB4, 3'd2, 1'b0, 1'b1);
      chk("t1_pre_valid", 32'(out_valid), 32'(0));
      chk("t1_head", 32'(sh_din), 32'(8'hB4));
      step();
      chk("t1_valid", 32'(out_valid), 32'(1));
      chk("t1_data", 32'(out_data), 32'(8'hED));
      step();
      chk("t1_drop", 32'(out_valid), 32'(0));

      // Back-to-back pushes
      in_valid = 1'b1; in_din = 8'h81; in_shamt = 3'd1; in_lr = 1'b1; in_al = 1'b0;
      step();
      in_din = 8'h80; in_shamt = 3'd7; in_lr = 1'b0; in_al = 1'b0;
      step();
      in_valid = 1'b0;
      junk();
      chk("t2_first", 32'(out_data), 32'(8'h02));
      step();
      chk("t2_second", 32'(out_data), 32'(8'h01));
      chk("t2_valid", 32'(out_valid), 32'(1));
      step();
      chk("t2_drop", 32'(out_valid), 32'(0));

      // Stalled output fills the queue
      out_ready = 1'b0;
      push_cmd(8'h01, 3'd1, 1'b1, 1'b0);
      push_cmd(8'h40, 3'd2, 1'b0, 1'b0);
      push_cmd(8'h90, 3'd1, 1'b0, 1'b1);
      push_cmd(8'hFF, 3'd3, 1'b1, 1'b0);
      push_cmd(8'h7E, 3'd4, 1'b0, 1'b1);
      chk("t3_valid", 32'(out_valid), 32'(1));
      chk("t3_held", 32'(out_data), 32'(8'h02));
      chk("t3_count", 32'(count), 32'(4));
      chk("t3_in_ready", 32'(in_ready), 32'(0));

      // Full queue: push offered while a pop frees a slot is still refused
      in_valid = 1'b1; in_din = 8'hAA; in_shamt = 3'd1; in_lr = 1'b1; in_al = 1'b0;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      junk();
      chk("t4_count", 32'(count), 32'(3));
      chk("t4_in_ready", 32'(in_ready), 32'(1));
      chk("t4_d1", 32'(out_data), 32'(8'h10));
      step();
      chk("t4_d2", 32'(out_data), 32'(8'hC8));
      step();
      chk("t4_d3", 32'(out_data), 32'(8'hF8));
      step();
      chk("t4_d4", 32'(out_data), 32'(8'h07));
      step();
      chk("t4_empty_valid", 32'(out_valid), 32'(0));
      chk("t4_empty_count", 32'(count), 32'(0));

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      push_cmd(8'h11, 3'd1, 1'b1, 1'b0);
      push_cmd(8'h22, 3'd2, 1'b0, 1'b0);
      push_cmd(8'h33, 3'd3, 1'b0, 1'b1);
      push_cmd(8'h44, 3'd4, 1'b1, 1'b0);
      chk("t5_pre_count", 32'(count), 32'(3));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t5_count", 32'(count), 32'(0));
      chk("t5_valid", 32'(out_valid), 32'(0));
      chk("t5_data", 32'(out_data), 32'(8'h00));
      chk("t5_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      push_cmd(8'h0F, 3'd4, 1'b1, 1'b0);
      step();
      chk("t5_post_valid", 32'(out_valid), 32'(1));
      chk("t5_post_data", 32'(out_data), 32'(8'hF0));
      step();

      // Random commands with random output stalls
      start = m_push_total;
      rnd_rdy = 1;
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            junk();
            step();
         end
         push_cmd(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      end
      rnd_rdy = 0;
      out_ready = 1'b1;
      wait_idle();
      chk("rand_pushes", 32'(m_push_total - start), 32'(20));
      chk("rand_leftover", 32'(exp_q.size()), 32'(0));
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
